// File: rtl/keypad_scan_onehot.sv
// 4x4 active-low matrix keypad scanner with debounce and one-hot key output.
// Optional auto-repeat of key_stb while held: define KEYPAD_AUTOREPEAT_EN.
module keypad_scan_onehot #(
  parameter int unsigned SCAN_DIV      = 50000,
  parameter int unsigned DEBOUNCE_CNT  = 20,
  parameter int unsigned REPEAT_DELAY  = 500,
  parameter int unsigned REPEAT_PERIOD = 100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  col_in,
  output logic [3:0]  row_out,
  output logic [15:0] onehot,
  output logic [3:0]  key_code,
  output logic        key_stb
);

  localparam int unsigned DIV_W = $clog2(SCAN_DIV);
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  if (SCAN_DIV < 4 || DEBOUNCE_CNT < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_cfg_check
    $error("keypad_scan_onehot: invalid parameter set");
  end

  typedef enum logic [1:0] {SCAN, DEB_P, PRESSED, DEB_R} state_t;

  logic [3:0]       r_col_meta, r_col_s;
  logic [DIV_W-1:0] r_div;
  state_t           r_state, w_state;
  logic [1:0]       r_row, w_row;
  logic [1:0]       r_col, w_col;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic [15:0]      r_onehot, w_onehot;
  logic [3:0]       r_key_code, w_key_code;
  logic             r_key_stb, w_key_stb;

  logic             w_tick;
  logic             w_one_low;
  logic [1:0]       w_col_idx;
  logic [3:0]       w_col_held;
  logic [CNT_W-1:0] w_cnt_inc;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int unsigned HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned HOLD_W   = $clog2(HOLD_MAX + 1);
  localparam logic [HOLD_W-1:0] HOLD_DLY = HOLD_W'(REPEAT_DELAY);
  localparam logic [HOLD_W-1:0] HOLD_PER = HOLD_W'(REPEAT_PERIOD);

  logic [HOLD_W-1:0] r_hold, w_hold, w_hold_inc, w_hold_lim;
  logic              r_rep, w_rep;

  assign w_hold_inc = r_hold + 1'b1;
  assign w_hold_lim = r_rep ? HOLD_PER : HOLD_DLY;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold <= '0;
      r_rep  <= 1'b0;
    end else begin
      r_hold <= w_hold;
      r_rep  <= w_rep;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col_meta <= '1;
      r_col_s    <= '1;
      r_div      <= '0;
    end else begin
      r_col_meta <= col_in;
      r_col_s    <= r_col_meta;
      r_div      <= (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
    end
  end

  assign w_tick     = (r_div == DIV_LAST);
  assign w_col_held = ~(4'b0001 << r_col);
  assign w_cnt_inc  = (r_cnt == CNT_LAST) ? r_cnt : r_cnt + 1'b1;

  always_comb begin
    w_one_low = 1'b1;
    w_col_idx = 2'd0;
    case (r_col_s)
      4'b1110: w_col_idx = 2'd0;
      4'b1101: w_col_idx = 2'd1;
      4'b1011: w_col_idx = 2'd2;
      4'b0111: w_col_idx = 2'd3;
      default: w_one_low = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= SCAN;
      r_row      <= '0;
      r_col      <= '0;
      r_cnt      <= '0;
      r_onehot   <= '0;
      r_key_code <= '0;
      r_key_stb  <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_row      <= w_row;
      r_col      <= w_col;
      r_cnt      <= w_cnt;
      r_onehot   <= w_onehot;
      r_key_code <= w_key_code;
      r_key_stb  <= w_key_stb;
    end
  end

  always_comb begin
    w_state    = r_state;
    w_row      = r_row;
    w_col      = r_col;
    w_cnt      = r_cnt;
    w_onehot   = r_onehot;
    w_key_code = r_key_code;
    w_key_stb  = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
    w_hold     = r_hold;
    w_rep      = r_rep;
`endif
    if (w_tick) begin
      case (r_state)
        SCAN: begin
          if (w_one_low) begin
            w_col   = w_col_idx;
            w_cnt   = CNT_ONE;
            w_state = DEB_P;
          end else begin
            w_row = r_row + 1'b1;
          end
        end
        DEB_P: begin
          if (r_col_s == w_col_held) begin
            w_cnt = w_cnt_inc;
            if (w_cnt_inc == CNT_LAST) begin
              w_onehot   = 16'h0001 << {r_row, r_col};
              w_key_code = {r_row, r_col};
              w_key_stb  = 1'b1;
              w_state    = PRESSED;
            end
          end else begin
            w_cnt   = '0;
            w_state = SCAN;
            w_row   = r_row + 1'b1;
          end
        end
        PRESSED: begin
`ifdef KEYPAD_AUTOREPEAT_EN
          if (r_col_s == 4'hF) begin
            w_cnt   = CNT_ONE;
            w_state = DEB_R;
            w_hold  = '0;
            w_rep   = 1'b0;
          end else if (w_hold_inc == w_hold_lim) begin
            w_key_stb = 1'b1;
            w_hold    = '0;
            w_rep     = 1'b1;
          end else begin
            w_hold = w_hold_inc;
          end
`else
          if (r_col_s == 4'hF) begin
            w_cnt   = CNT_ONE;
            w_state = DEB_R;
          end
`endif
        end
        DEB_R: begin
          if (r_col_s == 4'hF) begin
            w_cnt = w_cnt_inc;
            if (w_cnt_inc == CNT_LAST) begin
              w_onehot = '0;
              w_cnt    = '0;
              w_state  = SCAN;
              w_row    = r_row + 1'b1;
            end
          end else if (r_col_s == w_col_held) begin
            // bounce back onto the same key: resume holding without a new strobe
            w_cnt   = '0;
            w_state = PRESSED;
          end
        end
        default: w_state = SCAN;
      endcase
    end
  end

  assign row_out  = ~(4'b0001 << r_row);
  assign onehot   = r_onehot;
  assign key_code = r_key_code;
  assign key_stb  = r_key_stb;

endmodule
